mmio_io_bank: RTL and testbench
===============================

Name: mmio_io_bank

Overview:
- Parametrised memory-mapped I/O bank. Sits between the CPU data-memory port and the board I/O.
- Decodes a contiguous register window starting at BASE_ADDR. It provides:
  - synchronised, debounced button levels;
  - sticky rising-edge flags, cleared by writing 1;
  - NUM_REG writable control registers that drive fabric outputs, for example texture select.
- Addresses outside the window pass memory read data through unchanged. An optional interrupt line is available.

Parameters:
- ADDR_W, 12: address width.
- BASE_ADDR, 1000: word address of register offset 0.
- NUM_BTN, 4: number of button inputs, 1..32.
- NUM_REG, 4: number of control registers, 1..8.
- REG_W, 4: width of each control register, 1..32.
- DB_CYCLES, 100000: consecutive stable cycles required before the debounced level changes. Minimum 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  CPU word address.
- mwe  in  1  write enable for the current addr.
- wdata  in  32  CPU write data.
- mem_rdata  in  32  data-RAM read data, passed through for unmapped addresses.
- rdata  out  32  read data returned to the CPU.
- btn_in  in  NUM_BTN  raw asynchronous button inputs.
- ctrl_out  out  NUM_REG*REG_W  control registers; register i occupies bits [i*REG_W +: REG_W].
- irq  out  1  interrupt request; driven only with IRQ_EN, otherwise constant 0.

Behaviour:
- Register map, as word offset from BASE_ADDR:
  - +0 BTN_LEVEL, read-only.
  - +1 BTN_EDGE, read / write-1-to-clear.
  - +2 .. +1+NUM_REG: CTRL[0..NUM_REG-1], read/write.
  - +2+NUM_REG: IRQ_MASK, only with IRQ_EN.
  - Any other address, including writes to +0, is ignored for writes. For reads, rdata = mem_rdata.
- Reads are combinational, with zero latency:
  - rdata = register value zero-extended to 32 bits when addr hits a mapped offset;
  - rdata = mem_rdata otherwise.
- Writes take effect at the rising clk edge where mwe=1. CTRL[i] <= wdata[REG_W-1:0].
- Reset (rst_n=0, asynchronous) clears all of the following to 0:
  - CTRL, ctrl_out, debounced levels, edge flags, IRQ_MASK;
  - synchroniser flops and debounce counters;
  - irq.
- Synchroniser: two flops per button. Raw btn_in never feeds logic directly.
- Debounce, per button, independent. A counter runs while the synchronised value differs from the stable level:
  - it resets to 0 whenever the two agree;
  - when the count reaches DB_CYCLES-1 while they still differ, the stable level takes the synchronised value and the counter resets;
  - total latency from a btn_in change to the BTN_LEVEL change is 2 + DB_CYCLES cycles;
  - a glitch shorter than DB_CYCLES cycles produces no level change;
  - the counter width is clog2(DB_CYCLES)+1, and the counter never wraps.
- Edge flags: flag[b] is set in the cycle after stable level b goes 0->1. Falling edges are ignored.
- Edge-flag clearing: writing BTN_EDGE clears each flag[b] whose wdata[b]=1; bits with wdata[b]=0 are unaffected.
- Simultaneous set and clear of the same flag in one cycle: set wins, so the flag stays 1.
- Reset in mid-debounce discards the pending count. After release the level stays 0 until a new full stable window completes.
- NUM_BTN bits above the implemented width read as 0.

Optional Feature:
- Macro MMIO_IRQ_EN.
- Defined:
  - IRQ_MASK register exists at +2+NUM_REG, NUM_BTN bits, read/write;
  - irq is registered: irq <= |(edge_flags & IRQ_MASK), so it asserts 1 cycle after the flag/mask condition is true;
  - irq deasserts 1 cycle after the last enabled flag is cleared or masked.
- Undefined:
  - irq is tied to 0;
  - offset +2+NUM_REG is unmapped, so reads return mem_rdata and writes are ignored.

Test Plan (DB_CYCLES=4, defaults otherwise):
- Reset, then read addr 1000, 1001, 1002 -> rdata 0, 0, 0. Read addr 50 with mem_rdata=32'hDEADBEEF -> rdata 32'hDEADBEEF. ctrl_out=0.
- Write wdata=32'h0000_00A7 to addr 1003 -> ctrl_out[7:4]=4'h7, read 1003 -> 32'h7. Write to addr 1000 -> no effect.
- btn_in[2] high for 3 cycles, then low -> BTN_LEVEL stays 0. btn_in[2] held high -> BTN_LEVEL=32'h4 exactly 6 cycles after assertion, and BTN_EDGE=32'h4 one cycle later.
- With BTN_EDGE=32'h5: write 32'h1 to 1001 -> 32'h4. Repeat with a new bit-2 rising edge landing in the same cycle as a write of 32'h4 -> bit 2 remains 1.
- Assert rst_n=0 mid-debounce (count 2), release, hold button -> level rises only after a full 4 stable cycles post-sync.
- With MMIO_IRQ_EN: IRQ_MASK(addr 1006)=32'h1, bit-0 edge -> irq=1 the next cycle. W1C bit 0 -> irq=0 one cycle later. Bit-1 edge with mask 0 -> irq stays 0.

Source files
------------

// File: rtl/mmio_io_bank.sv
// mmio_io_bank: memory-mapped I/O register bank between the CPU data port and
// the board I/O. It decodes a word-address window starting at BASE_ADDR:
//   +0                BTN_LEVEL  (RO)   synchronised, debounced button levels
//   +1                BTN_EDGE   (W1C)  sticky rising-edge flags
//   +2 .. +1+NUM_REG  CTRL[i]    (RW)   control registers driving ctrl_out
//   +2+NUM_REG        IRQ_MASK   (RW)   only when MMIO_IRQ_EN is defined
// Reads are combinational. Any address that is not mapped returns mem_rdata.
// Optional feature: define MMIO_IRQ_EN to add IRQ_MASK and a registered irq.
// Without it, irq is tied to 0 and offset +2+NUM_REG is unmapped.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   addr       CPU word address            [ADDR_W]
//   mwe        write enable for addr
//   wdata      CPU write data              [32]
//   mem_rdata  data-RAM read data, used for unmapped reads [32]
//   rdata      read data returned to the CPU [32]
//   btn_in     raw asynchronous buttons    [NUM_BTN]
//   ctrl_out   control registers, reg i at [i*REG_W +: REG_W]
//   irq        interrupt request
module mmio_io_bank #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 1000,
  parameter int unsigned NUM_BTN   = 4,
  parameter int unsigned NUM_REG   = 4,
  parameter int unsigned REG_W     = 4,
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       mwe,
  input  logic [31:0]                wdata,
  input  logic [31:0]                mem_rdata,
  output logic [31:0]                rdata,
  input  logic [NUM_BTN-1:0]         btn_in,
  output logic [NUM_REG*REG_W-1:0]   ctrl_out,
  output logic                       irq
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [31:0] OFF_LEVEL = 32'd0;
  localparam logic [31:0] OFF_EDGE  = 32'd1;
  localparam logic [31:0] OFF_CTRL  = 32'd2;
`ifdef MMIO_IRQ_EN
  localparam logic [31:0] OFF_MASK  = 32'(2 + NUM_REG);
`endif

  // Address decode: offset is only meaningful when addr is at or above the base
  logic [31:0] addr_ext;
  logic [31:0] off;
  logic        in_win;
  logic        hit_level;
  logic        hit_edge;

  assign addr_ext  = 32'(addr);
  assign in_win    = (addr_ext >= 32'(BASE_ADDR));
  assign off       = addr_ext - 32'(BASE_ADDR);
  assign hit_level = in_win && (off == OFF_LEVEL);
  assign hit_edge  = in_win && (off == OFF_EDGE);

`ifdef MMIO_IRQ_EN
  logic hit_mask;
  assign hit_mask = in_win && (off == OFF_MASK);
`endif

  // Parts of wdata above the widest register are intentionally ignored
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Two-flop synchroniser; raw btn_in feeds nothing else
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: level follows sync only after DB_CYCLES disagreeing cycles
  logic [NUM_BTN-1:0] level;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (sync2_q[b] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[b];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign level[b] = lvl_q;
  end

  // Sticky rising-edge flags; a set in the same cycle as a clear wins
  logic [NUM_BTN-1:0] level_d_q;
  logic [NUM_BTN-1:0] flag_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] edge_clr;

  assign rise     = level & ~level_d_q;
  assign edge_clr = (mwe && hit_edge) ? wdata[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_q <= '0;
      flag_q    <= '0;
    end else begin
      level_d_q <= level;
      flag_q    <= (flag_q & ~edge_clr) | rise;
    end
  end

  // Control registers, stored flat in ctrl_out layout
  logic [NUM_REG*REG_W-1:0] ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (mwe && in_win) begin
      for (int unsigned i = 0; i < NUM_REG; i++) begin
        if (off == OFF_CTRL + 32'(i)) begin
          ctrl_q[i*REG_W +: REG_W] <= wdata[REG_W-1:0];
        end
      end
    end
  end

  assign ctrl_out = ctrl_q;

`ifdef MMIO_IRQ_EN
  // Interrupt mask and registered interrupt request
  logic [NUM_BTN-1:0] mask_q;
  logic               irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (mwe && hit_mask) begin
        mask_q <= wdata[NUM_BTN-1:0];
      end
      irq_q <= |(flag_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Zero-latency read mux; unmapped addresses fall through to data RAM
  always_comb begin
    rdata = mem_rdata;
    if (hit_level) begin
      rdata = 32'(level);
    end else if (hit_edge) begin
      rdata = 32'(flag_q);
    end
`ifdef MMIO_IRQ_EN
    else if (hit_mask) begin
      rdata = 32'(mask_q);
    end
`endif
    for (int unsigned i = 0; i < NUM_REG; i++) begin
      if (in_win && (off == OFF_CTRL + 32'(i))) begin
        rdata = 32'(ctrl_q[i*REG_W +: REG_W]);
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_bank.sv
// Scoreboard bench for mmio_io_bank with DB_CYCLES=4. The driver issues one
// cycle per call and may push an expected value; the monitor samples on the
// falling edge whenever a probe is raised and compares against the queue head.
module tb_mmio_io_bank;

  localparam int PK_NONE = 0;
  localparam int PK_RD   = 1;
  localparam int PK_CTRL = 2;
  localparam int PK_IRQ  = 3;
  localparam logic [31:0] MEMD = 32'hA5A5_5A5A;
`ifdef MMIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic        mwe;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic [3:0]  btn_in;
  logic [15:0] ctrl_out;
  logic        irq;
  logic        probe;

  int checks = 0;
  int errors = 0;

  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];

  mmio_io_bank #(
    .ADDR_W(12), .BASE_ADDR(1000), .NUM_BTN(4),
    .NUM_REG(4), .REG_W(4), .DB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .mwe(mwe), .wdata(wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .btn_in(btn_in),
    .ctrl_out(ctrl_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: compare the selected DUT output with the queued expectation
  always @(negedge clk) begin
    int          k;
    logic [31:0] ex;
    logic [31:0] act;
    string       nm;
    if (probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: probe raised with empty expectation queue");
      end else begin
        k  = kind_q.pop_front();
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        case (k)
          PK_CTRL: act = 32'(ctrl_out);
          PK_IRQ:  act = 32'(irq);
          default: act = rdata;
        endcase
        if (act !== ex) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, ex);
        end
      end
    end
  end

  // One bus cycle; inputs change 1 time unit after the rising edge
  task automatic cyc(input logic [11:0] a, input logic we, input logic [31:0] wd,
                     input logic [31:0] mr, input int pk, input logic [31:0] ex,
                     input string nm);
    addr = a; mwe = we; wdata = wd; mem_rdata = mr;
    if (pk != PK_NONE) begin
      kind_q.push_back(pk);
      exp_q.push_back(ex);
      name_q.push_back(nm);
      probe = 1'b1;
    end else begin
      probe = 1'b0;
    end
    @(posedge clk);
    #1;
    mwe = 1'b0;
    probe = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ex, input string nm);
    cyc(a, 1'b0, 32'h0, MEMD, PK_RD, ex, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd);
    cyc(a, 1'b1, wd, MEMD, PK_NONE, 32'h0, "");
  endtask

  task automatic idle();
    cyc(12'd0, 1'b0, 32'h0, MEMD, PK_NONE, 32'h0, "");
  endtask

  task automatic chk_ctrl(input logic [31:0] ex, input string nm);
    cyc(12'd0, 1'b0, 32'h0, MEMD, PK_CTRL, ex, nm);
  endtask

  task automatic chk_irq(input logic [31:0] ex, input string nm);
    cyc(12'd0, 1'b0, 32'h0, MEMD, PK_IRQ, ex, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; addr = '0; mwe = 1'b0; wdata = '0; mem_rdata = '0;
    btn_in = '0; probe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and pass-through
    rd(12'd1000, 32'h0, "rst_level");
    rd(12'd1001, 32'h0, "rst_edge");
    rd(12'd1002, 32'h0, "rst_ctrl0");
    cyc(12'd50, 1'b0, 32'h0, 32'hDEADBEEF, PK_RD, 32'hDEADBEEF, "unmapped_50");
    chk_ctrl(32'h0, "rst_ctrl_out");
    chk_irq(32'h0, "rst_irq");

    // Control register writes, read-only offset, window edges
    wr(12'd1003, 32'h0000_00A7);
    chk_ctrl(32'h0070, "ctrl1_out");
    rd(12'd1003, 32'h7, "ctrl1_rd");
    wr(12'd1000, 32'h0000_000F);
    chk_ctrl(32'h0070, "ro_write_ctrl");
    rd(12'd1000, 32'h0, "ro_write_level");
    wr(12'd1002, 32'h0000_0003);
    wr(12'd1005, 32'hFFFF_FFFC);
    chk_ctrl(32'hC073, "ctrl_all_out");
    rd(12'd1005, 32'hC, "ctrl3_rd");
    cyc(12'd999, 1'b0, 32'h0, 32'h1111_2222, PK_RD, 32'h1111_2222, "below_window");
    cyc(12'd1006, 1'b0, 32'h0, 32'h1234_5678, PK_RD,
        IRQ_ON ? 32'h0 : 32'h1234_5678, "offset_mask_rd");
    cyc(12'd1007, 1'b0, 32'h0, 32'h8765_4321, PK_RD, 32'h8765_4321, "above_window");

    // Three-cycle glitch on button 2 must not change the level
    btn_in = 4'b0100;
    repeat (3) rd(12'd1000, 32'h0, "glitch_high");
    btn_in = 4'b0000;
    repeat (6) rd(12'd1000, 32'h0, "glitch_after");

    // Held button 2: level exactly 6 cycles later, edge flag one cycle after
    btn_in = 4'b0100;
    for (int i = 0; i < 6; i++) rd(12'd1000, 32'h0, "hold_level_early");
    rd(12'd1000, 32'h4, "hold_level_6");
    rd(12'd1001, 32'h4, "hold_edge_7");

    // Add a bit-0 edge, then write-1-to-clear bit 0 only
    btn_in = 4'b0101;
    repeat (7) idle();
    rd(12'd1001, 32'h5, "edge_both");
    cyc(12'd1001, 1'b1, 32'h1, MEMD, PK_RD, 32'h5, "w1c_same_cycle");
    rd(12'd1001, 32'h4, "w1c_bit0");
    wr(12'd1001, 32'h4);
    rd(12'd1001, 32'h0, "w1c_bit2");

    // Falling edge updates the level but sets no flag
    btn_in = 4'b0001;
    repeat (8) idle();
    rd(12'd1000, 32'h1, "fall_level");
    rd(12'd1001, 32'h0, "fall_no_flag");

    // New bit-2 rise lands in the same cycle as a clear of bit 2: set wins
    btn_in = 4'b0101;
    repeat (6) idle();
    cyc(12'd1001, 1'b1, 32'h4, MEMD, PK_RD, 32'h0, "set_wins_pre");
    rd(12'd1001, 32'h4, "set_wins");
    wr(12'd1001, 32'h4);
    rd(12'd1001, 32'h0, "w1c_again");

    // Reset in mid-debounce (count 2) discards progress
    btn_in = 4'b0111;
    repeat (4) idle();
    rst_n = 1'b0;
    chk_ctrl(32'h0, "rst_mid_ctrl");
    rst_n = 1'b1;
    rd(12'd1001, 32'h0, "rst_mid_edge");
    repeat (5) rd(12'd1000, 32'h0, "rst_mid_level_early");
    rd(12'd1000, 32'h7, "rst_mid_level_full");

    // Interrupt path (expectations collapse to 0 / pass-through without IRQ)
    rst_n = 1'b0;
    btn_in = 4'b0000;
    idle();
    rst_n = 1'b1;
    wr(12'd1006, 32'h1);
    cyc(12'd1006, 1'b0, 32'h0, 32'hCAFE_F00D, PK_RD,
        IRQ_ON ? 32'h1 : 32'hCAFE_F00D, "mask_rd");
    btn_in = 4'b0001;
    for (int i = 0; i < 8; i++) chk_irq(32'h0, "irq_before_flag");
    cyc(12'd1001, 1'b1, 32'h1, MEMD, PK_IRQ, 32'(IRQ_ON), "irq_set");
    chk_irq(32'(IRQ_ON), "irq_hold");
    chk_irq(32'h0, "irq_cleared");
    btn_in = 4'b0011;
    for (int i = 0; i < 8; i++) chk_irq(32'h0, "irq_masked");
    rd(12'd1001, 32'h2, "edge_bit1");
    chk_irq(32'h0, "irq_masked_after");

    // Every queued expectation must have been consumed by the monitor
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
